// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one 8-bit UART transmitter among NUM_REQ byte producers.
// A grant stays locked to one requester until the byte flagged req_last has been sent.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int BUSY_TO = 16,
    parameter int LOCK_TO = 1024
) (
    input  logic                 tx_clk,
    input  logic                 tx_rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic [2:0]           grant_id,
    output logic                 lock_active,
    output logic                 err_busy_to,
    output logic                 err_lock_to
);
    localparam int BW = $clog2(BUSY_TO + 1);
    localparam int LW = $clog2(LOCK_TO + 1);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t             state;
    logic [BW-1:0]      busy_cnt;
    logic [LW-1:0]      lock_cnt;
    logic [NUM_REQ-1:0] eligible;
    logic               win_found;
    logic [2:0]         win_idx;
    logic [7:0]         win_data;
    logic               win_last;
    logic               xfer;

    // While locked only the current owner competes; the search still starts at grant_id+1
    // and wraps, so the owner is reached at offset NUM_REQ.
    always_comb begin
        eligible = lock_active ? (req_valid & (ONE << grant_id)) : req_valid;
        win_found = 1'b0;
        win_idx   = '0;
        win_data  = '0;
        win_last  = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            automatic int idx = (int'(grant_id) + k) % NUM_REQ;
            if (eligible[idx]) begin
                win_found = 1'b1;
                win_idx   = 3'(idx);
                win_data  = req_data[8*idx +: 8];
                win_last  = req_last[idx];
            end
        end
    end

    assign xfer      = (state == IDLE) && !tx_busy && win_found;
    assign req_ready = xfer ? (ONE << win_idx) : '0;

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state       <= IDLE;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            grant_id    <= 3'(NUM_REQ - 1);
            lock_active <= 1'b0;
            err_busy_to <= 1'b0;
            err_lock_to <= 1'b0;
            busy_cnt    <= '0;
            lock_cnt    <= '0;
        end else begin
            tx_start    <= 1'b0;
            err_busy_to <= 1'b0;
            err_lock_to <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        tx_data     <= win_data;
                        grant_id    <= win_idx;
                        lock_active <= ~win_last;
                        lock_cnt    <= '0;
                        tx_start    <= 1'b1;
                        state       <= LAUNCH;
                    end else if (lock_active && !(|eligible)) begin
                        if (lock_cnt == LW'(LOCK_TO - 1)) begin
                            err_lock_to <= 1'b1;
                            lock_active <= 1'b0;
                            lock_cnt    <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + LW'(1);
                        end
                    end
                end
                LAUNCH: begin
                    // counter holds cycles elapsed since the tx_start cycle
                    busy_cnt <= BW'(1);
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (busy_cnt == BW'(BUSY_TO - 1)) begin
                        err_busy_to <= 1'b1;
                        lock_active <= 1'b0;
                        lock_cnt    <= '0;
                        state       <= IDLE;
                    end else begin
                        busy_cnt <= busy_cnt + BW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (tx_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
